// File: rtl/bft_pkg.sv
// Shared BFT packet definitions.
// Packet layout (49 bits):
//   [48] valid, [47:44] leaf, [43:40] port, [39:33] seq, [32] ctrl, [31:0] payload.
// Data packets carry ctrl=0. Credit packets carry ctrl=1, and payload[7:0] holds
// the number of credits being returned.
package bft_pkg;

  localparam int PACKET_BITS  = 49;
  localparam int PAYLOAD_BITS = 32;
  localparam int LEAF_BITS    = 4;
  localparam int PORT_BITS    = 4;
  localparam int SEQ_BITS     = 7;
  localparam int CREDIT_BITS  = 8;

  localparam int VALID_POS = 48;
  localparam int PORT_LSB  = 40;
  localparam int CTRL_POS  = 32;

  localparam logic CTRL_DATA   = 1'b0;
  localparam logic CTRL_CREDIT = 1'b1;

  typedef logic [PACKET_BITS-1:0] packet_t;

  // Staging FIFO entry: 40 bits = leaf + port + payload.
  typedef struct packed {
    logic [LEAF_BITS-1:0]    leaf;
    logic [PORT_BITS-1:0]    port;
    logic [PAYLOAD_BITS-1:0] payload;
  } fifo_entry_t;

  function automatic packet_t make_packet(
    input logic [LEAF_BITS-1:0]    leaf,
    input logic [PORT_BITS-1:0]    port,
    input logic [SEQ_BITS-1:0]     seq,
    input logic                    ctrl,
    input logic [PAYLOAD_BITS-1:0] payload
  );
    return {1'b1, leaf, port, seq, ctrl, payload};
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with registered full/empty flags.
// Ports:
//   clk, reset      clock, synchronous active-high reset (discards contents)
//   push, wdata     write request/data; ignored while full
//   pop             read request; ignored while empty
//   rdata           head-of-queue entry (valid when !empty)
//   full, empty     registered status flags
module sync_fifo #(
  parameter int WIDTH      = 40,
  parameter int DEPTH_BITS = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int DEPTH = 1 << DEPTH_BITS;
  localparam logic [DEPTH_BITS:0] DEPTH_CNT = {1'b1, {DEPTH_BITS{1'b0}}};

  logic [WIDTH-1:0]      mem_q [DEPTH];
  logic [DEPTH_BITS-1:0] wr_ptr_q, wr_ptr_d;
  logic [DEPTH_BITS-1:0] rd_ptr_q, rd_ptr_d;
  logic [DEPTH_BITS:0]   count_q, count_d;
  logic                  full_q, full_d;
  logic                  empty_q, empty_d;
  logic                  do_push, do_pop;

  // A push at full is refused even if a pop happens in the same cycle.
  assign do_push = push & ~full_q;
  assign do_pop  = pop & ~empty_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    // Flags are precomputed from the next count so they come straight off flops.
    full_d  = (count_d == DEPTH_CNT);
    empty_d = (count_d == '0);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
    end
  end

  // Storage needs no reset: the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end

  assign rdata = mem_q[rd_ptr_q];
  assign full  = full_q;
  assign empty = empty_q;

endmodule

// File: rtl/leaf_stream_packetizer.sv
// User-to-network send path for one leaf output port.
// Accepts 32-bit words on an ap_vld/ap_ack stream, stages them in a 16-deep FIFO
// and emits 49-bit BFT data packets, gated by credits returned in freespace
// packets arriving on din_leaf_bft2interface.
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   din_leaf_user2interface    user payload word
//   vld_user2interface         payload valid (ap_vld)
//   ack_interface2user         payload accepted this cycle (ap_ack, combinational)
//   dest_leaf, dest_port       destination, sampled with each accepted word
//   din_leaf_bft2interface     incoming packets; only credit updates for SRC_PORT are used
//   dout_leaf_interface2bft    outgoing packet, registered
//   resend                     single-cycle request to re-emit the last data packet
//   credits                    current credit count
module leaf_stream_packetizer
  import bft_pkg::*;
#(
  parameter int PACKET_BITS     = 49,
  parameter int PAYLOAD_BITS    = 32,
  parameter int NUM_LEAF_BITS   = 4,
  parameter int NUM_PORT_BITS   = 4,
  parameter int NUM_ADDR_BITS   = 7,
  parameter int FIFO_DEPTH_BITS = 4,
  parameter int SRC_PORT        = 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [PAYLOAD_BITS-1:0]  din_leaf_user2interface,
  input  logic                     vld_user2interface,
  output logic                     ack_interface2user,
  input  logic [NUM_LEAF_BITS-1:0] dest_leaf,
  input  logic [NUM_PORT_BITS-1:0] dest_port,
  input  logic [PACKET_BITS-1:0]   din_leaf_bft2interface,
  output logic [PACKET_BITS-1:0]   dout_leaf_interface2bft,
  input  logic                     resend,
  output logic [CREDIT_BITS-1:0]   credits
);

  localparam logic [CREDIT_BITS-1:0]   CREDIT_INIT = CREDIT_BITS'(2 ** NUM_ADDR_BITS);
  localparam logic [NUM_PORT_BITS-1:0] MY_PORT     = NUM_PORT_BITS'(SRC_PORT);
  localparam logic [CREDIT_BITS+1:0]   CREDIT_MAX  = {2'b00, {CREDIT_BITS{1'b1}}};

  fifo_entry_t                wr_entry, rd_entry;
  logic                       fifo_full, fifo_empty;
  logic                       emit, resend_eff, credit_hit;
  logic [CREDIT_BITS-1:0]     credit_n;
  logic [CREDIT_BITS+1:0]     credit_sum;

  logic [NUM_ADDR_BITS-1:0]   seq_q, seq_d;
  logic [CREDIT_BITS-1:0]     credits_q, credits_d;
  packet_t                    dout_q, dout_d;
  packet_t                    last_q, last_d;
  logic                       sent_q, sent_d;

  logic                       unused_din_bits;

  assign ack_interface2user = vld_user2interface & ~fifo_full & ~reset;
  assign wr_entry = '{leaf: dest_leaf, port: dest_port, payload: din_leaf_user2interface};

  sync_fifo #(
    .WIDTH      ($bits(fifo_entry_t)),
    .DEPTH_BITS (FIFO_DEPTH_BITS)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (ack_interface2user),
    .wdata (wr_entry),
    .pop   (emit),
    .rdata (rd_entry),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Credit updates: valid, ctrl=1 and addressed to this port.
  assign credit_hit = din_leaf_bft2interface[VALID_POS]
                    & (din_leaf_bft2interface[CTRL_POS] == CTRL_CREDIT)
                    & (din_leaf_bft2interface[PORT_LSB +: NUM_PORT_BITS] == MY_PORT);
  assign credit_n   = credit_hit ? din_leaf_bft2interface[CREDIT_BITS-1:0] : '0;

  // Resend before anything was sent has nothing to replay, so it is dropped
  // and does not block a normal emit.
  assign resend_eff = resend & sent_q;
  assign emit       = ~fifo_empty & (credits_q != '0) & ~resend_eff;

  // credits never underflows here: emit implies credits_q >= 1.
  assign credit_sum = {2'b00, credits_q} - {{(CREDIT_BITS+1){1'b0}}, emit}
                    + {2'b00, credit_n};

  always_comb begin
    seq_d     = seq_q;
    last_d    = last_q;
    sent_d    = sent_q;
    dout_d    = '0;
    credits_d = (credit_sum > CREDIT_MAX) ? CREDIT_MAX[CREDIT_BITS-1:0]
                                          : credit_sum[CREDIT_BITS-1:0];
    if (resend_eff) begin
      dout_d = last_q;
    end else if (emit) begin
      dout_d = make_packet(rd_entry.leaf, rd_entry.port, seq_q, CTRL_DATA, rd_entry.payload);
      last_d = dout_d;
      sent_d = 1'b1;
      seq_d  = seq_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      seq_q     <= '0;
      credits_q <= CREDIT_INIT;
      dout_q    <= '0;
      last_q    <= '0;
      sent_q    <= 1'b0;
    end else begin
      seq_q     <= seq_d;
      credits_q <= credits_d;
      dout_q    <= dout_d;
      last_q    <= last_d;
      sent_q    <= sent_d;
    end
  end

  assign dout_leaf_interface2bft = dout_q;
  assign credits                 = credits_q;

  // Leaf, seq and upper payload bits of incoming packets play no role on the send side.
  assign unused_din_bits = ^{din_leaf_bft2interface[PACKET_BITS-2:PORT_LSB+NUM_PORT_BITS],
                             din_leaf_bft2interface[PORT_LSB-1:CTRL_POS+1],
                             din_leaf_bft2interface[CTRL_POS-1:CREDIT_BITS]};

endmodule
